// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe constants, line table, fallback order and opponent FSM states
package ttt_pkg;
  localparam logic [1:0] VACIA = 2'b00;
  localparam logic [1:0] J1    = 2'b01;
  localparam logic [1:0] J2    = 2'b10;
  // rows, columns, then the two diagonals
  localparam logic [3:0] LINEAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  // centre, corners, then edges
  localparam logic [3:0] ORDEN [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
  typedef enum logic [2:0] {IDLE, SNAP, WIN, BLOCK, PICK, DELAY, ISSUE, HOLD} estado_t;
endpackage

// File: rtl/evalua_linea.sv
// evalua_linea: combinational test of one three-cell line for "two of sim plus one empty"
//   a, b, c : cells of the line in table order
//   sim     : symbol being counted (J2 to win, J1 to block)
//   hit     : line is one move from three-in-a-row for sim
//   off     : position (0..2) of the empty cell within the line
module evalua_linea
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] sim,
  output logic       hit,
  output logic [1:0] off
);
  always_comb begin
    hit = (a == sim && b == sim && c == VACIA) ||
          (a == sim && c == sim && b == VACIA) ||
          (b == sim && c == sim && a == VACIA);
    off = a == VACIA ? 2'd0 : b == VACIA ? 2'd1 : 2'd2;
  end
endmodule

// File: rtl/jugador_automatico.sv
// jugador_automatico: automatic player-2 opponent (win, block, fixed fallback order)
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   turno      : high while it is player 2's turn; a move starts on its rising edge
//   pos0..pos8 : board cells (00 empty, 01 player 1, 10 player 2, 11 occupied)
//   posj2      : chosen cell 0..8, held between moves
//   j2         : one-cycle move strobe
//   ocupado    : busy from the snapshot until back in IDLE
//   sin_jugada : one-cycle pulse when the snapshot has no empty cell
//   ESPERA_MIN : extra cycles spent in DELAY before the strobe (0..255)
//   BLOQUEO_EN : when defined, a blocking scan runs between the win scan and the fallback
module jugador_automatico
  import ttt_pkg::*;
#(
  parameter int ESPERA_MIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turno,
  input  logic [1:0] pos0,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  output logic [3:0] posj2,
  output logic       j2,
  output logic       ocupado,
  output logic       sin_jugada
);
`ifdef BLOQUEO_EN
  localparam estado_t TRAS_WIN = BLOCK;
`else
  localparam estado_t TRAS_WIN = PICK;
`endif
  estado_t    estado;
  logic       turno_d, flanco, hit, vacia;
  logic [2:0] linea;
  logic [7:0] cnt;
  logic [1:0] off;
  logic [3:0] mov, pick;
  logic [1:0] pos  [9];
  logic [1:0] snap [9];
  assign pos = '{pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8};
  assign j2 = estado == ISSUE;
  assign ocupado = estado != IDLE;
  // one evaluator, stepped across the eight lines by the line counter
  evalua_linea u_eval (
    .a  (snap[LINEAS[linea][0]]),
    .b  (snap[LINEAS[linea][1]]),
    .c  (snap[LINEAS[linea][2]]),
    .sim(estado == WIN ? J2 : J1),
    .hit(hit),
    .off(off)
  );
  always_comb begin
    vacia = 1'b0;
    for (int i = 0; i < 9; i++) vacia = vacia | (pos[i] == VACIA);
  end
  // walk the preference list backwards so the earliest empty entry wins
  always_comb begin
    pick = 4'd0;
    for (int i = 8; i >= 0; i--) pick = snap[ORDEN[i]] == VACIA ? ORDEN[i] : pick;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado     <= IDLE;
      turno_d    <= 1'b0;
      flanco     <= 1'b0;
      linea      <= 3'd0;
      cnt        <= 8'd0;
      mov        <= 4'd0;
      posj2      <= 4'd0;
      sin_jugada <= 1'b0;
      snap       <= '{default: VACIA};
    end else begin
      turno_d    <= turno;
      flanco     <= turno & ~turno_d;
      sin_jugada <= 1'b0;
      if (!turno && estado != IDLE && estado != HOLD) estado <= IDLE;
      else
        case (estado)
          IDLE: if (flanco) estado <= SNAP;
          SNAP: begin
            snap       <= pos;
            linea      <= 3'd0;
            sin_jugada <= ~vacia;
            estado     <= vacia ? WIN : HOLD;
          end
          WIN, BLOCK: begin
            // the counter wraps to 0 after line 7, ready for the next scan
            linea <= hit ? 3'd0 : linea + 3'd1;
            cnt   <= 8'd0;
            mov   <= LINEAS[linea][off];
            estado <= hit ? DELAY : linea != 3'd7 ? estado : estado == WIN ? TRAS_WIN : PICK;
          end
          PICK: begin
            mov    <= pick;
            cnt    <= 8'd0;
            estado <= DELAY;
          end
          DELAY: begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(ESPERA_MIN)) begin
              posj2  <= mov;
              estado <= ISSUE;
            end
          end
          ISSUE: estado <= HOLD;
          HOLD: if (!turno) estado <= IDLE;
          default: estado <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_jugador_automatico.sv
// tb_jugador_automatico: random and directed turns against a rule-level model, two delay settings
module tb_jugador_automatico;
`ifdef BLOQUEO_EN
  localparam int FASES = 2, FALLBACK = 20;
`else
  localparam int FASES = 1, FALLBACK = 12;
`endif
  logic clk = 1'b0, rst = 1'b0, turno = 1'b0;
  logic [1:0] p [9];
  logic [3:0] posj2_a, posj2_b;
  logic j2_a, j2_b, oc_a, oc_b, sin_a, sin_b;
  int cyc = 0, checks = 0, errors = 0;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int orden [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
  int esp [2] = '{0, 5};
  bit has_turn = 1'b0, m_full = 1'b0;
  int t0 = 0, tl = 0, m_lat = 0, m_mv = 0;
  int m_pos [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jugador_automatico #(.ESPERA_MIN(0)) dut_a (
    .clk(clk), .rst(rst), .turno(turno),
    .pos0(p[0]), .pos1(p[1]), .pos2(p[2]), .pos3(p[3]), .pos4(p[4]),
    .pos5(p[5]), .pos6(p[6]), .pos7(p[7]), .pos8(p[8]),
    .posj2(posj2_a), .j2(j2_a), .ocupado(oc_a), .sin_jugada(sin_a));
  jugador_automatico #(.ESPERA_MIN(5)) dut_b (
    .clk(clk), .rst(rst), .turno(turno),
    .pos0(p[0]), .pos1(p[1]), .pos2(p[2]), .pos3(p[3]), .pos4(p[4]),
    .pos5(p[5]), .pos6(p[6]), .pos7(p[7]), .pos8(p[8]),
    .posj2(posj2_b), .j2(j2_b), .ocupado(oc_b), .sin_jugada(sin_b));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // move and latency straight from the rules: win, then block, then preference order
  function automatic void decide(input logic [1:0] b [9], output int mv, output int lat, output bit full);
    int own, free, e;
    full = 1'b1;
    mv = 0;
    lat = -1;
    for (int i = 0; i < 9; i++) if (b[i] == 2'b00) full = 1'b0;
    if (full) return;
    for (int ph = 0; ph < FASES; ph++)
      for (int k = 0; k < 8; k++) begin
        own = 0; free = 0; e = 0;
        for (int j = 0; j < 3; j++) begin
          if (b[lines[k][j]] == (ph == 0 ? 2'b10 : 2'b01)) own++;
          if (b[lines[k][j]] == 2'b00) begin free++; e = lines[k][j]; end
        end
        if (own == 2 && free == 1) begin
          mv = e;
          lat = 4 + 8 * ph + k;
          return;
        end
      end
    lat = FALLBACK;
    for (int i = 8; i >= 0; i--) if (b[orden[i]] == 2'b00) mv = orden[i];
  endfunction

  task automatic rand_board(output logic [1:0] b [9]);
    bit lleno;
    int r;
    lleno = $urandom_range(0, 7) == 0;
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(lleno ? 4 : 0, 9);
      b[i] = r < 4 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
    end
  endtask

  // compare every cycle: strobe timing, held position, busy window, no-move pulse
  always @(negedge clk) begin
    bit e_oc, e_sin, e_j2 [2];
    e_oc  = has_turn && cyc >= t0 + 1 && cyc < tl;
    e_sin = has_turn && m_full && cyc == t0 + 2 && cyc < tl;
    for (int d = 0; d < 2; d++) begin
      e_j2[d] = has_turn && !m_full && cyc == t0 + m_lat + esp[d] && cyc < tl;
      if (e_j2[d]) m_pos[d] = m_mv;
    end
    chk("j2_e0", int'(j2_a), int'(e_j2[0]));
    chk("j2_e5", int'(j2_b), int'(e_j2[1]));
    chk("posj2_e0", int'(posj2_a), m_pos[0]);
    chk("posj2_e5", int'(posj2_b), m_pos[1]);
    chk("ocupado_e0", int'(oc_a), int'(e_oc));
    chk("ocupado_e5", int'(oc_b), int'(e_oc));
    chk("sin_jugada_e0", int'(sin_a), int'(e_sin));
    chk("sin_jugada_e5", int'(sin_b), int'(e_sin));
  end

  // called #1 after a rising edge; turno drops so that edge t0+drop samples it low
  task automatic turn(input logic [1:0] b [9], input int drop, input bit scr);
    int mv, lat;
    bit full;
    logic [1:0] nb [9];
    decide(b, mv, lat, full);
    p = b;
    turno = 1'b1;
    t0 = cyc + 1;
    tl = 1 << 30;
    m_mv = mv;
    m_lat = lat;
    m_full = full;
    has_turn = 1'b1;
    do begin
      @(posedge clk);
      #1;
      if (scr && cyc >= t0 + 2) begin
        rand_board(nb);
        p = nb;
      end
    end while (cyc + 1 < t0 + drop);
    turno = 1'b0;
    tl = cyc + 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] b_win [9], b_blk [9], b_vac [9], b_c4 [9], b_full [9], b [9];
    int mv, lat;
    bit full;
    b_win  = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    b_blk  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    b_vac  = '{default: 2'b00};
    b_c4   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    b_full = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
    p = b_vac;
    decide(b_win, mv, lat, full);
    chk("model_win_mv", mv, 2);
    chk("model_win_lat", lat, 4);
    decide(b_blk, mv, lat, full);
`ifdef BLOQUEO_EN
    chk("model_block_mv", mv, 8);
    chk("model_block_lat", lat, 18);
`else
    chk("model_block_mv", mv, 2);
    chk("model_block_lat", lat, 12);
`endif
    decide(b_vac, mv, lat, full);
    chk("model_empty_mv", mv, 4);
    chk("model_empty_lat", lat, FALLBACK);
    decide(b_c4, mv, lat, full);
    chk("model_c4_mv", mv, 0);
    decide(b_full, mv, lat, full);
    chk("model_full", int'(full), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_posj2", int'(posj2_a), 0);
    chk("reset_j2", int'(j2_a), 0);
    chk("reset_ocupado", int'(oc_b), 0);
    chk("reset_sin_jugada", int'(sin_b), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    turn(b_win, 30, 1'b1);
    turn(b_blk, 30, 1'b0);
    turn(b_vac, 30, 1'b1);
    turn(b_c4, 30, 1'b0);
    turn(b_full, 10, 1'b0);
    turn(b_blk, 13, 1'b0);
    // reset while the delayed instance sits in DELAY and the other already moved
    p = b_win;
    decide(b_win, mv, lat, full);
    turno = 1'b1;
    t0 = cyc + 1;
    tl = 1 << 30;
    m_mv = mv;
    m_lat = lat;
    m_full = full;
    has_turn = 1'b1;
    while (cyc < t0 + 6) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_posj2_e0", int'(posj2_a), 2);
    chk("pre_rst_ocupado_e5", int'(oc_b), 1);
    rst = 1'b0;
    turno = 1'b0;
    has_turn = 1'b0;
    m_pos = '{0, 0};
    #1;
    chk("rst_posj2_e0", int'(posj2_a), 0);
    chk("rst_ocupado_e5", int'(oc_b), 0);
    chk("rst_j2_e5", int'(j2_b), 0);
    chk("rst_sin_e5", int'(sin_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 70; n++) begin
      rand_board(b);
      turn(b, $urandom_range(0, 2) == 0 ? int'($urandom_range(2, 26)) : 30, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jugador_automatico.md
# jugador_automatico

Automatic opponent for the tic-tac-toe datapath: samples the nine 2-bit board cells, selects a legal move for player 2, and drives the player-2 position nibble plus a one-cycle move strobe back into the game logic. It sits opposite the game core's board outputs and feeds its `posj2`/`j2` inputs directly, replacing a human second player. Selection is a multi-cycle scan of the eight winning lines: win first, then block, then a fixed fallback order.

## Interface
Parameters:
- `ESPERA_MIN`, default 0: extra idle cycles inserted before the strobe, for visible "thinking" delay; valid range 0–255.

Ports:
- `clk`, in, 1: single system clock; everything is rising-edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `turno`, in, 1: level high while it is player 2's turn.
- `pos0`..`pos8`, in, 2 each: board cells; 2'b00 empty, 2'b01 player 1, 2'b10 player 2, 2'b11 treated as occupied.
- `posj2`, out, 4: chosen cell index 0–8; values 9–15 are never driven.
- `j2`, out, 1: one-cycle move strobe; `posj2` is valid in that cycle.
- `ocupado`, out, 1: high from the snapshot until return to IDLE.
- `sin_jugada`, out, 1: one-cycle pulse when the snapshot has no empty cell.

## Operation
- States are IDLE, SNAP, WIN, BLOCK, PICK, DELAY, ISSUE and HOLD.
- IDLE -> SNAP on the rising edge of `turno` (registered edge detect).
- SNAP: latch pos0..pos8 into a 9x2 snapshot. All later decisions use only the snapshot. If no cell is 2'b00, pulse `sin_jugada` and go to HOLD. Otherwise go to WIN.
- WIN: a line counter (3-bit) evaluates one line per cycle, lines 0–7. Hit condition: two cells are 2'b10 and one is 2'b00. On a hit, the empty cell index goes to the move register and the FSM goes to DELAY. After line 7 with no hit, go to BLOCK.
- BLOCK: same scan with the hit condition "two cells are 2'b01, one is 2'b00". Hit goes to DELAY; no hit goes to PICK.
- PICK (one cycle): take the first empty cell in the order 4, 0, 2, 6, 8, 1, 3, 5, 7, then go to DELAY.
- DELAY: count `ESPERA_MIN` cycles; when 0, pass through in one cycle. Then go to ISSUE.
- ISSUE: `j2`=1 and `posj2`=move for exactly one cycle, then go to HOLD.
- HOLD: wait until `turno`=0, then go to IDLE. A new turn needs a fresh rising edge.
- Abort: `turno` low in any state other than IDLE or HOLD returns the FSM to IDLE next cycle, with no `j2` and no `sin_jugada`.
- `posj2` holds its last issued value between moves.

## Timing
- Reset values: state IDLE; `posj2`=0, `j2`=0, `ocupado`=0, `sin_jugada`=0; line counter, delay counter and snapshot all 0.
- Latency is measured from the cycle `turno` is first sampled high to the `j2` cycle:
  - win on line k: 3 + k + `ESPERA_MIN` + 1;
  - block on line k: 11 + k + `ESPERA_MIN` + 1;
  - fallback: 19 + `ESPERA_MIN` + 1;
  - worst case with `ESPERA_MIN`=0 is 20 cycles.
- `ocupado` rises in the SNAP cycle and falls on entry to IDLE.
- Reset mid-operation: all state clears immediately; no partial strobe.
- Simultaneous win and block availability: win always takes precedence.
- Multiple hits in one phase: the lowest line index wins.

## Configuration
- `BLOQUEO_EN` defined: the BLOCK phase is present as described.
- `BLOQUEO_EN` undefined: WIN goes directly to PICK, and fallback latency drops to 11 + `ESPERA_MIN` + 1.

## Structure
- Shared package `ttt_pkg` holds:
  - cell constants `VACIA`=2'b00, `J1`=2'b01, `J2`=2'b10;
  - `LINEAS[8][3]` index table: rows 012, 345, 678, columns 036, 147, 258, diagonals 048, 246;
  - the fallback order array;
  - the FSM state enum.
- One combinational sub-module, `evalua_linea`:
  - inputs: three cells and a target symbol;
  - outputs: `hit` and the 2-bit offset of the empty cell;
  - a single instance is time-shared across the scan.

## Test plan
- Win: board 2'b10 at cells 0 and 1, 2'b01 at cells 3 and 4, all others empty; raise `turno` -> `j2` pulses once with `posj2`=2 at latency 4.
- Block: 2'b01 at 0 and 4, 2'b10 at 1, all others empty -> `posj2`=8, found via the diagonal line 6, latency 18. With `BLOQUEO_EN` undefined -> fallback `posj2`=2.
- Empty board -> `posj2`=4 at latency 20. With only cell 4 occupied -> `posj2`=0.
- Full board, no empty cell -> `sin_jugada` pulses once, `j2` never asserts, and the FSM waits in HOLD until `turno`=0.
- Abort: drop `turno` during BLOCK cycle 3 -> no `j2`, `ocupado`=0 next cycle. Assert `rst`=0 during DELAY with `ESPERA_MIN`=5 -> all outputs return to 0 immediately.
